// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared definitions for the digit-classification engine and its
//            host-side driver: engine geometry, class-index width, the host
//            driver state encoding and the class code reported on timeout.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int N_LIP = 256;              // engine input image bits
    localparam int N_LOP = 10;               // number of output classes
    localparam int CLS_W = $clog2(N_LOP);    // class index width

    // Class code reported when the engine never signals done
    localparam logic [CLS_W-1:0] ERR_CLASS = {CLS_W{1'b1}};

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        OUT       = 2'd3
    } host_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_host_if.sv
`default_nettype none
// ============================================================================
// Module   : nn_host_if
// Purpose  : Host-side driver for the nn engine. Assembles a binary image from
//            a narrow valid/ready stream, runs the engine start/ack/done
//            handshake as initiator and returns the class on a valid/ready
//            result port, flagging framing, timeout and range errors.
// Ports    : clk, rst (async, active-high)
//            s_valid/s_ready/s_data/s_last : pixel beat stream in
//            nn_xi/nn_start/nn_ack/nn_done/nn_yi : engine handshake
//            m_valid/m_ready/m_class/m_err : result stream out
//            busy : high whenever not accepting image beats
// Revision : 1.0 - initial release
// ============================================================================
module nn_host_if
    import nn_pkg::*;
#(
    parameter int NPIX    = N_LIP,
    parameter int PW      = 16,
    parameter int NCLS    = N_LOP,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PW-1:0]           s_data,
    input  logic                    s_last,
    output logic [NPIX-1:0]         nn_xi,
    output logic                    nn_start,
    input  logic                    nn_ack,
    input  logic                    nn_done,
    input  logic [$clog2(NCLS)-1:0] nn_yi,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(NCLS)-1:0] m_class,
    output logic                    m_err,
    output logic                    busy
);

    localparam int c_NBEAT = NPIX / PW;
    localparam int c_CW    = $clog2(NCLS);
    localparam int c_BW    = (c_NBEAT > 1) ? $clog2(c_NBEAT) : 1;
    localparam int c_TW    = $clog2(TIMEOUT + 1);

    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_NBEAT - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT - 1);
    localparam logic [c_CW:0]   c_NCLS      = (c_CW + 1)'(NCLS);
    localparam logic [c_CW-1:0] c_ERR_CLASS = {c_CW{1'b1}};

    host_state_t      r_state;
    host_state_t      w_state_next;
    logic [c_BW-1:0]  r_beat;
    logic [c_TW-1:0]  r_tmo_cnt;
    logic             r_frame_err;
    logic             r_done_q;
    logic [NPIX-1:0]  w_xi_next;
    logic             w_beat_acc;
    logic             w_at_last;
    logic             w_frame_end;
    logic             w_frame_bad;
    logic             w_done_rise;
    logic             w_timeout;
    logic             w_out_hs;
    logic             w_yi_bad;

    assign w_beat_acc  = s_valid & s_ready;
    assign w_at_last   = (r_beat == c_LAST_BEAT);
    assign w_frame_end = w_beat_acc & (s_last | w_at_last);
    // A frame is well formed only when s_last coincides with the final beat
    assign w_frame_bad = s_last ^ w_at_last;
    assign w_done_rise = nn_done & ~r_done_q;
    // Counter value one short of TIMEOUT: the limit is reached at this edge
    assign w_timeout   = (r_tmo_cnt == c_TMO_LAST);
    assign w_out_hs    = m_valid & m_ready;
    assign w_yi_bad    = ({1'b0, nn_yi} >= c_NCLS);

    // First beat of a frame starts from an all-zero image, so bits of an
    // early-terminated frame stay 0 and nothing from the last frame leaks.
    always_comb begin
        w_xi_next = (r_beat == '0) ? '0 : nn_xi;
        w_xi_next[int'(r_beat) * PW +: PW] = s_data;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: begin
                if (w_frame_end) w_state_next = START;
            end
            START: begin
                if (w_timeout)   w_state_next = OUT;
                else if (nn_ack) w_state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_done_rise || w_timeout) w_state_next = OUT;
            end
            OUT: begin
                if (w_out_hs) w_state_next = LOAD;
            end
            default: w_state_next = LOAD;
        endcase
    end

    always_comb begin
        s_ready = (r_state == LOAD);
        busy    = (r_state != LOAD);
    end

    // ------------------------------------------------- registered datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_tmo_cnt   <= '0;
            r_frame_err <= 1'b0;
            r_done_q    <= 1'b0;
            nn_xi       <= '0;
            nn_start    <= 1'b0;
            m_valid     <= 1'b0;
            m_class     <= '0;
            m_err       <= 1'b0;
        end else begin
            // done_q is frozen in START so a done edge rising together with
            // ack is still seen as an edge in the first WAIT_DONE cycle; a
            // level-high done left over from the last frame is tracked
            // through LOAD and therefore produces no edge.
            if (r_state != START) r_done_q <= nn_done;

            case (r_state)
                LOAD: begin
                    if (w_beat_acc) begin
                        nn_xi <= w_xi_next;
                        if (w_frame_end) begin
                            r_beat      <= '0;
                            r_tmo_cnt   <= '0;
                            nn_start    <= 1'b1;
                            r_frame_err <= r_frame_err | w_frame_bad;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                START: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_timeout) begin
                        nn_start <= 1'b0;
                        m_valid  <= 1'b1;
                        m_class  <= c_ERR_CLASS;
                        m_err    <= 1'b1;
                    end else if (nn_ack) begin
                        nn_start <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (w_done_rise) begin
                        m_valid <= 1'b1;
                        m_class <= nn_yi;
                        m_err   <= r_frame_err | w_yi_bad;
                    end else if (w_timeout) begin
                        m_valid <= 1'b1;
                        m_class <= c_ERR_CLASS;
                        m_err   <= 1'b1;
                    end
                end
                OUT: begin
                    if (w_out_hs) begin
                        m_valid     <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_host_if
// Purpose  : Self-checking bench for nn_host_if with a behavioural engine
//            driven from scenario tasks and a reference image/error model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_host_if;
    import nn_pkg::*;

    localparam int NPIX    = N_LIP;
    localparam int PW      = 16;
    localparam int NBEAT   = NPIX / PW;
    localparam int NCLS    = N_LOP;
    localparam int CW      = $clog2(NCLS);
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [PW-1:0]   s_data;
    logic            s_last;
    logic [NPIX-1:0] nn_xi;
    logic            nn_start;
    logic            nn_ack;
    logic            nn_done;
    logic [CW-1:0]   nn_yi;
    logic            m_valid;
    logic            m_ready;
    logic [CW-1:0]   m_class;
    logic            m_err;
    logic            busy;

    nn_host_if #(.NPIX(NPIX), .PW(PW), .NCLS(NCLS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .nn_xi(nn_xi), .nn_start(nn_start), .nn_ack(nn_ack), .nn_done(nn_done),
        .nn_yi(nn_yi), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .m_err(m_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] beats [NBEAT];

    // ------------------------------------------------------ reference model
    function automatic logic [NPIX-1:0] model_image(input int n);
        logic [NPIX-1:0] img;
        img = '0;
        for (int i = 0; i < n; i++)
            img = img | ({{(NPIX-PW){1'b0}}, beats[i]} << (i * PW));
        return img;
    endfunction

    // last_idx < 0 means the stream never raises s_last
    function automatic int frame_len(input int last_idx);
        return (last_idx < 0 || last_idx >= NBEAT) ? NBEAT : last_idx + 1;
    endfunction

    function automatic logic model_err(input int last_idx, input int yi);
        return (last_idx != NBEAT - 1) || (yi >= NCLS);
    endfunction

    // ------------------------------------------------------- stimulus tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int last_idx, input bit gaps);
        int n;
        n = frame_len(last_idx);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    s_data  = PW'($urandom);
                    s_last  = 1'($urandom);
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = beats[k];
            s_last  = (k == last_idx);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Engine raises ack lat cycles after seeing start; counts start-high cycles
    task automatic engine_ack(input int lat, output int start_cycles);
        start_cycles = 0;
        repeat (lat) begin
            if (nn_start) start_cycles++;
            tick();
        end
        nn_ack = 1'b1;
        if (nn_start) start_cycles++;
        tick();
        nn_ack = 1'b0;
    endtask

    // Engine raises done lat cycles later; counts any premature m_valid
    task automatic engine_done(input int lat, input int yi, output int early);
        early = 0;
        repeat (lat) begin
            if (m_valid) early++;
            tick();
        end
        nn_done = 1'b1;
        nn_yi   = CW'(yi);
        if (m_valid) early++;
        tick();
    endtask

    task automatic handshake(input bit drop_done);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        if (drop_done) nn_done = 1'b0;
    endtask

    // ------------------------------------------------------ scenario tests
    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        nn_ack = 1'b0; nn_done = 1'b0; nn_yi = '0; m_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({s_ready, nn_start, m_valid, m_err, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000", {s_ready, nn_start, m_valid, m_err, busy});
        end
        checks++;
        if (nn_xi !== '0) begin errors++; $display("FAIL reset_xi: got %h expected 0", nn_xi); end
        checks++;
        if (m_class !== '0) begin errors++; $display("FAIL reset_class: got %0d expected 0", m_class); end
        rst = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_nominal();
        int sc, early;
        for (int k = 0; k < NBEAT; k++) beats[k] = 16'hA5A5;
        send_frame(NBEAT - 1, 1'b0);
        checks++;
        if ({nn_start, s_ready, busy} !== 3'b101) begin
            errors++; $display("FAIL nom_start: got %b expected 101", {nn_start, s_ready, busy});
        end
        checks++;
        if (nn_xi !== model_image(NBEAT)) begin
            errors++; $display("FAIL nom_xi: got %h expected %h", nn_xi, model_image(NBEAT));
        end
        engine_ack(1, sc);
        checks++;
        if (sc != 2 || nn_start !== 1'b0) begin
            errors++; $display("FAIL nom_start_len: got %0d/%b expected 2/0", sc, nn_start);
        end
        engine_done(50, 7, early);
        checks++;
        if (early != 0 || m_valid !== 1'b1 || m_class !== CW'(7) || m_err !== 1'b0) begin
            errors++;
            $display("FAIL nom_result: got early=%0d v=%b c=%0d e=%b expected 0/1/7/0", early, m_valid, m_class, m_err);
        end
        handshake(1'b1);
        checks++;
        if ({m_valid, s_ready} !== 2'b01) begin
            errors++; $display("FAIL nom_hs: got %b expected 01", {m_valid, s_ready});
        end
    endtask

    task automatic test_early_last();
        int sc, early;
        for (int k = 0; k < NBEAT; k++) beats[k] = (k < 4) ? 16'hFFFF : PW'($urandom);
        send_frame(3, 1'b0);
        checks++;
        if (nn_xi !== model_image(4)) begin
            errors++; $display("FAIL early_xi: got %h expected %h", nn_xi, model_image(4));
        end
        engine_ack(1, sc);
        engine_done(10, 5, early);
        checks++;
        if (m_valid !== 1'b1 || m_class !== CW'(5) || m_err !== model_err(3, 5)) begin
            errors++; $display("FAIL early_result: got v=%b c=%0d e=%b expected 1/5/1", m_valid, m_class, m_err);
        end
        handshake(1'b1);
    endtask

    task automatic test_stale_done();
        int sc, early, c, n_res;
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b0);
        engine_ack(1, sc);
        engine_done(8, 3, early);
        handshake(1'b0);                       // done stays high
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b1);
        engine_ack(1, sc);
        c = 2;
        n_res = 0;
        while (c < 41) begin
            if (c == 7) nn_done = 1'b0;
            if (c == 40) begin nn_done = 1'b1; nn_yi = CW'(2); end
            if (m_valid) n_res++;
            tick();
            c++;
        end
        checks++;
        if (n_res != 0 || m_valid !== 1'b1 || m_class !== CW'(2) || m_err !== 1'b0) begin
            errors++;
            $display("FAIL stale_result: got early=%0d v=%b c=%0d e=%b expected 0/1/2/0", n_res, m_valid, m_class, m_err);
        end
        handshake(1'b1);
        n_res = 0;
        repeat (6) begin
            if (m_valid) n_res++;
            tick();
        end
        checks++;
        if (n_res != 0) begin errors++; $display("FAIL stale_dup: got %0d extra cycles expected 0", n_res); end
    endtask

    task automatic test_timeout();
        int sc, c, start_hi;
        logic [CW-1:0] exp_cls;
        exp_cls = '1;
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b1);
        engine_ack(1, sc);
        c = 2;
        start_hi = 0;
        while (!m_valid && c < 200) begin
            if (nn_start) start_hi++;
            tick();
            c++;
        end
        checks++;
        if (c != TIMEOUT) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", c, TIMEOUT); end
        checks++;
        if (m_class !== exp_cls || m_err !== 1'b1 || nn_start !== 1'b0 || start_hi != 0) begin
            errors++;
            $display("FAIL tmo_result: got c=%0h e=%b st=%b hi=%0d expected %0h/1/0/0", m_class, m_err, nn_start, start_hi, exp_cls);
        end
        handshake(1'b1);
    endtask

    task automatic test_backpressure();
        int sc, early, yi, bad;
        yi = $urandom_range(0, NCLS - 1);
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b0);
        engine_ack(2, sc);
        engine_done(5, yi, early);
        bad = 0;
        repeat (10) begin
            if (m_valid !== 1'b1 || m_class !== CW'(yi) || m_err !== 1'b0 || s_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        handshake(1'b1);
        checks++;
        if ({m_valid, s_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got %b expected 01", {m_valid, s_ready});
        end
    endtask

    task automatic test_reset_mid();
        int sc, early;
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b0);
        engine_ack(1, sc);
        repeat (5) tick();
        rst = 1'b1;
        #2;
        checks++;
        if ({s_ready, nn_start, m_valid, m_err, busy} !== 5'b10000 || nn_xi !== '0 || m_class !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %b xi=%h c=%0d expected 10000/0/0",
                     {s_ready, nn_start, m_valid, m_err, busy}, nn_xi, m_class);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
        send_frame(NBEAT - 1, 1'b1);
        checks++;
        if (nn_xi !== model_image(NBEAT)) begin
            errors++; $display("FAIL mid_next_xi: got %h expected %h", nn_xi, model_image(NBEAT));
        end
        engine_ack(1, sc);
        engine_done(12, 4, early);
        checks++;
        if (m_valid !== 1'b1 || m_class !== CW'(4) || m_err !== 1'b0) begin
            errors++; $display("FAIL mid_next_result: got v=%b c=%0d e=%b expected 1/4/0", m_valid, m_class, m_err);
        end
        handshake(1'b1);
    endtask

    task automatic test_random();
        int sc, early, last_idx, yi, alat, dlat, n;
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 2))
                0:       last_idx = -1;
                1:       last_idx = $urandom_range(0, NBEAT - 2);
                default: last_idx = NBEAT - 1;
            endcase
            yi   = $urandom_range(0, (1 << CW) - 1);
            alat = $urandom_range(1, 3);
            dlat = $urandom_range(1, 40);
            n    = frame_len(last_idx);
            for (int k = 0; k < NBEAT; k++) beats[k] = PW'($urandom);
            send_frame(last_idx, 1'b1);
            checks++;
            if (nn_xi !== model_image(n)) begin
                errors++; $display("FAIL rnd%0d_xi: got %h expected %h", it, nn_xi, model_image(n));
            end
            engine_ack(alat, sc);
            checks++;
            if (sc != alat + 1) begin
                errors++; $display("FAIL rnd%0d_start_len: got %0d expected %0d", it, sc, alat + 1);
            end
            engine_done(dlat, yi, early);
            checks++;
            if (early != 0 || m_valid !== 1'b1 || m_class !== CW'(yi) ||
                m_err !== model_err(last_idx, yi) || nn_xi !== model_image(n)) begin
                errors++;
                $display("FAIL rnd%0d_result: got early=%0d v=%b c=%0d e=%b expected 0/1/%0d/%b",
                         it, early, m_valid, m_class, m_err, yi, model_err(last_idx, yi));
            end
            repeat ($urandom_range(0, 3)) tick();
            handshake(1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_early_last();
        test_stale_done();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_host_if.md
# nn_host_if

Host-side driver for the digit-classification engine `nn`. It assembles a 256-pixel binary image from a narrow valid/ready stream and drives the engine's `start`/`ack`/`done` handshake as initiator. It then returns the predicted class on a valid/ready result port. It sits between the system bus adapter and `nn`, and is the only block that toggles `nn.start`.

## Interface
- `NPIX`, 256: image bits, equal to `nn` input width.
- `PW`, 16: pixel bits per input beat; `NPIX % PW == 0`; `NBEAT = NPIX/PW`.
- `NCLS`, 10: number of classes; `CW = $clog2(NCLS)`.
- `TIMEOUT`, 4096: max cycles from entering START to `done`; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: input beat accepted when `s_valid & s_ready`.
- `s_data`, in, PW: pixel chunk.
- `s_last`, in, 1: final beat of image.
- `nn_xi`, out, NPIX: image to engine.
- `nn_start`, out, 1: engine start request.
- `nn_ack`, in, 1: engine acknowledge.
- `nn_done`, in, 1: engine result ready.
- `nn_yi`, in, CW: engine class index.
- `m_valid`, out, 1: result valid.
- `m_ready`, in, 1: result consumed when `m_valid & m_ready`.
- `m_class`, out, CW: predicted class.
- `m_err`, out, 1: framing, timeout or range error for this result.
- `busy`, out, 1: high in any state other than LOAD.

## Operation
- **FSM states:** LOAD, START, WAIT_DONE, OUT. Reset state is LOAD.
- **LOAD**
  - `s_ready=1`.
  - Beat k (k = 0..NBEAT-1) writes `nn_xi[k*PW +: PW]`. The beat counter increments per accepted beat.
  - Accepted beat with `s_last=1` or `k=NBEAT-1` ends the frame and moves to START. The beat counter clears.
  - Early `s_last` (k < NBEAT-1): unwritten bits are forced to 0 and the sticky frame error flag is set.
  - Beat NBEAT-1 without `s_last`: frame ends and the frame error flag is set.
  - `nn_xi` is cleared to 0 at the first beat of each frame, before the write, so stale bits never leak.
- **START**
  - `nn_start=1`.
  - When `nn_ack` is sampled high, `nn_start` is registered low and the FSM moves to WAIT_DONE.
- **WAIT_DONE**
  - `nn_start=0`.
  - On `nn_done & !done_q` (rising edge; `done_q` is a register of `nn_done`), capture `nn_yi` into `m_class` and move to OUT.
  - A level-high `nn_done` present on entry is ignored until it falls and rises again.
- **OUT**
  - `m_valid=1` until `m_valid & m_ready`, then return to LOAD.
  - `m_class` and `m_err` are held stable while `m_valid=1`.
- **Errors**
  - `m_err` = frame error | timeout | (`nn_yi >= NCLS`).
  - Timeout: the counter clears on entering START and counts in START and WAIT_DONE. When it reaches TIMEOUT: `m_class = {CW{1'b1}}`, `m_err=1`, `nn_start` drops, go to OUT.
  - The frame error flag clears on entering LOAD.
- `nn_xi` holds stable from the end of LOAD until the next frame's first beat.

## Timing
- **Reset values:** `s_ready=1`, `nn_start=0`, `nn_xi=0`, `m_valid=0`, `m_class=0`, `m_err=0`, `busy=0`, `done_q=0`.
- **Registered outputs:** all outputs except `s_ready` and `busy`, which decode directly from the state register.
- **LOAD throughput:** one beat per cycle; NBEAT cycles minimum per image.
- **Start timing:** `nn_start` rises the cycle after the final beat is accepted. It falls the cycle after `nn_ack` is sampled high; minimum START dwell is 1 cycle.
- **Result timing:** `m_valid` rises the cycle after the `nn_done` rising edge is sampled. The driver adds 3 cycles overhead over the engine's ack/done latency.
- **Simultaneous `nn_ack` and `nn_done` rise in START:** go to WAIT_DONE. The edge is preserved via `done_q` and caught in the next cycle only if `nn_done` is still high; otherwise a timeout occurs.
- **Back-to-back frames:** `s_ready=0` outside LOAD; no frame overlap.
- **Reset mid-operation:** immediate return to LOAD, all outputs at reset values. The partial frame is discarded. `nn` shares `rst`.

## Structure
- Shared package `nn_pkg` holds:
  - `N_LIP=256`, `N_LOP=10`, `CLS_W=$clog2(N_LOP)`.
  - State enum `host_state_t` {LOAD, START, WAIT_DONE, OUT}.
  - `ERR_CLASS={CLS_W{1'b1}}`.
- Single module; no sub-module. Edge detection and the timeout counter are inline.

## Test plan
- **Nominal:** 16 beats of `16'hA5A5`, `s_last` on beat 15, behavioural `nn` with ack after 1 cycle, done after 50 cycles, yi=7 → `nn_xi` = 16 copies of `16'hA5A5`; `nn_start` high 2 cycles; `m_valid` with `m_class=7`, `m_err=0`.
- **Early last:** `s_last` on beat 3 with data `16'hFFFF` → `nn_xi[63:0]` all 1s, bits 255:64 = 0; result `m_err=1`, class passed through.
- **Stale done:** `nn_done` held high from the prior frame, falls 5 cycles after ack, rises at cycle 40 with yi=2 → exactly one result, `m_class=2`.
- **Timeout:** `TIMEOUT=64`, engine never asserts done → `m_valid` 64 cycles after entering START, `m_class=4'hF`, `m_err=1`, `nn_start=0`.
- **Backpressure:** `m_ready` low for 10 cycles → `m_valid`/`m_class` stable; `s_ready=0` throughout; after handshake, `s_ready=1` the next cycle.
- **Reset mid-WAIT_DONE:** assert `rst` → all outputs at reset values, FSM in LOAD; the next full frame classifies correctly.
